// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core. One shared, wait-state-capable memory port
// serves both instruction fetch and load/store data access.
module mips_multicycle_core #(
   parameter int              XLEN     = 32,
   parameter int              ADDR_W   = 10,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   instr_count
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_LI   = 6'b001001;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_JR   = 6'b001000;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, mdr_q, mdr_d, alu_q, alu_d, cnt_q, cnt_d;
   logic [31:0]     ir_q, ir_d;
   logic [XLEN-1:0] rf_q [32];

   logic            rf_we, retire;
   logic [4:0]      rf_wa;
   logic [XLEN-1:0] rf_wd;

   logic [5:0]      op, fn;
   logic [4:0]      rs, rt, rd;
   logic [XLEN-1:0] simm, jtgt, rs_val, rt_val;
   logic            unused_shamt;

   assign op           = ir_q[31:26];
   assign rs           = ir_q[25:21];
   assign rt           = ir_q[20:16];
   assign rd           = ir_q[15:11];
   assign fn           = ir_q[5:0];
   assign unused_shamt = ^ir_q[10:6];
   assign simm         = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
   assign jtgt         = {pc_q[XLEN-1:26], ir_q[25:0]};
   assign rs_val       = (rs == 5'd0) ? '0 : rf_q[rs];
   assign rt_val       = (rt == 5'd0) ? '0 : rf_q[rt];

   // Memory port decoded from registered state only; reset masks it at once.
   assign mem_req     = ~reset & ((state_q == S_FETCH) | (state_q == S_MEM));
   assign mem_we      = ~reset & (state_q == S_MEM) & (op == OP_SW);
   assign mem_addr    = (state_q == S_MEM) ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
   assign mem_wdata   = b_q;
   assign halted      = (state_q == S_HALT);
   assign pc          = pc_q;
   assign instr_count = cnt_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      mdr_d   = mdr_q;
      alu_d   = alu_q;
      rf_we   = 1'b0;
      rf_wa   = 5'd0;
      rf_wd   = '0;
      retire  = 1'b0;
      unique case (state_q)
         S_FETCH: if (mem_ready) begin
            ir_d    = mem_rdata[31:0];
            pc_d    = pc_q + XLEN'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d = rs_val;
            b_d = rt_val;
            case (op)
               OP_J: begin
                  pc_d = jtgt; retire = 1'b1; state_d = S_FETCH;
               end
               OP_JAL: begin
                  rf_we = 1'b1; rf_wa = 5'd31; rf_wd = pc_q;
                  pc_d = jtgt; retire = 1'b1; state_d = S_FETCH;
               end
               OP_LI: begin
                  rf_we = 1'b1; rf_wa = rt; rf_wd = simm;
                  retire = 1'b1; state_d = S_FETCH;
               end
               OP_BNE, OP_BEQ: begin
                  alu_d = pc_q + simm; state_d = S_EXEC;
               end
               OP_R: state_d = (fn inside {FN_ADD, FN_SUB, FN_SLT, FN_JR}) ? S_EXEC : S_HALT;
               OP_LW, OP_SW, OP_XORI: state_d = S_EXEC;
               default: state_d = S_HALT;
            endcase
         end
         S_EXEC: begin
            state_d = S_WB;
            case (op)
               OP_R: case (fn)
                  FN_ADD: alu_d = a_q + b_q;
                  FN_SUB: alu_d = a_q - b_q;
                  FN_SLT: alu_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                  default: begin
                     pc_d = a_q; retire = 1'b1; state_d = S_FETCH;
                  end
               endcase
               OP_XORI: alu_d = a_q ^ simm;
               OP_LW, OP_SW: begin
                  alu_d = a_q + simm; state_d = S_MEM;
               end
               default: begin
                  // Branch target was computed in DECODE from PC+1.
                  if ((op == OP_BNE) ? (a_q != b_q) : (a_q == b_q)) pc_d = alu_q;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: if (mem_ready) begin
            if (op == OP_SW) begin
               retire = 1'b1; state_d = S_FETCH;
            end else begin
               mdr_d = mem_rdata; state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            rf_wa   = (op == OP_R) ? rd : rt;
            rf_wd   = (op == OP_LW) ? mdr_q : alu_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
      cnt_d = retire ? cnt_q + XLEN'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mdr_q   <= '0;
         alu_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mdr_q   <= mdr_d;
         alu_q   <= alu_d;
         cnt_q   <= cnt_d;
      end
   end

   // $0 is never written, so it reads back as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rf_we && rf_wa != 5'd0) begin
         rf_q[rf_wa] <= rf_wd;
      end
   end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: wait-state memory model, store scoreboard,
// latency, branch/jump, halt and mid-access reset scenarios.
module tb_mips_multicycle_core;
   localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101, OP_LI = 6'b001001, OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_SLT = 6'b101010, FN_JR = 6'b001000;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_we, mem_ready, halted;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata, pc, instr_count;

   logic [31:0] mem  [0:1023];
   logic [31:0] prog [0:1023];
   logic        load;
   int          wait_n, wcnt;

   wr_t         exp_wr[$];
   int          n_tests = 0, n_fail = 0, cyc = 0;
   logic        stall_prev;
   logic [9:0]  h_addr;
   logic        h_we;
   logic [31:0] h_wdata;

   mips_multicycle_core #(.XLEN(32), .ADDR_W(10), .RESET_PC(32'd0)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .halted(halted), .pc(pc), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Memory: each access sees wait_n not-ready cycles before acceptance.
   assign mem_ready = mem_req && (wcnt == wait_n);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 1024; i++) mem[i] <= prog[i];
      end else if (mem_req && mem_ready && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      if (reset || !mem_req || mem_ready) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, fn};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
      return {op, 26'(tgt)};
   endfunction

   task automatic push_wr(input int addr, input int data);
      wr_t w;
      w.addr = 10'(addr);
      w.data = 32'(data);
      exp_wr.push_back(w);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
   endtask

   // One cycle: sample at negedge, check held outputs and retiring stores.
   task automatic tick();
      wr_t e;
      @(negedge clk);
      cyc++;
      if (!reset && mem_req) begin
         if (stall_prev) begin
            chk("hold_addr", 32'(mem_addr), 32'(h_addr));
            chk("hold_we", 32'(mem_we), 32'(h_we));
            chk("hold_wdata", mem_wdata, h_wdata);
         end
         if (mem_ready && mem_we) begin
            if (exp_wr.size() == 0) begin
               chk("wr_unexpected", 32'(mem_addr), 32'h3ff);
            end else begin
               e = exp_wr.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(e.addr));
               chk("wr_data", mem_wdata, e.data);
            end
         end
         stall_prev = !mem_ready;
         h_addr     = mem_addr;
         h_we       = mem_we;
         h_wdata    = mem_wdata;
      end else begin
         stall_prev = 1'b0;
      end
   endtask

   task automatic start(input int wt);
      reset  = 1'b1;
      load   = 1'b1;
      wait_n = wt;
      @(negedge clk);
      @(negedge clk);
      load       = 1'b0;
      reset      = 1'b0;
      cyc        = 0;
      stall_prev = 1'b0;
   endtask

   task automatic run_to_count(input string tag, input int target, input int budget);
      int n = 0;
      while (instr_count != 32'(target) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, instr_count, 32'(target));
   endtask

   task automatic run_to_halt(input string tag, input int exp_cnt, input int exp_pc);
      int n = 0;
      int reqs = 0;
      while (!halted && n < 500) begin
         tick();
         n++;
      end
      chk({tag, "_halted"}, 32'(halted), 32'd1);
      chk({tag, "_pc"}, pc, 32'(exp_pc));
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_req) reqs++;
      end
      chk({tag, "_quiet"}, 32'(reqs), 32'd0);
      chk({tag, "_cnt"}, instr_count, 32'(exp_cnt));
      chk({tag, "_sb_left"}, 32'(exp_wr.size()), 32'd0);
   endtask

   initial begin
      clear_prog();
      reset  = 1'b1;
      load   = 1'b1;
      wait_n = 0;
      stall_prev = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", pc, 32'd0);
      chk("rst_cnt", instr_count, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);

      // Arithmetic, signed compare, sign-extended XORI, zero-wait latency.
      clear_prog();
      prog[0]  = enc_i(OP_LI, 0, 1, 5);
      prog[1]  = enc_i(OP_LI, 0, 2, -3);
      prog[2]  = enc_r(1, 2, 3, FN_ADD);
      prog[3]  = enc_r(2, 1, 4, FN_SLT);
      prog[4]  = enc_i(OP_SW, 0, 3, 'h20);
      prog[5]  = enc_i(OP_SW, 0, 4, 'h21);
      prog[6]  = enc_r(2, 1, 6, FN_SUB);
      prog[7]  = enc_i(OP_SW, 0, 6, 'h22);
      prog[8]  = enc_i(OP_XORI, 2, 7, 'h00f0);
      prog[9]  = enc_i(OP_XORI, 1, 8, 'hffff);
      prog[10] = enc_i(OP_SW, 0, 7, 'h23);
      prog[11] = enc_i(OP_SW, 0, 8, 'h24);
      prog[12] = enc_r(1, 2, 9, FN_SLT);
      prog[13] = enc_i(OP_SW, 0, 9, 'h25);
      prog[14] = 32'hfc00_0000;
      push_wr('h20, 2);
      push_wr('h21, 1);
      push_wr('h22, 32'hffff_fff8);
      push_wr('h23, 32'hffff_ff0d);
      push_wr('h24, 32'hffff_fffa);
      push_wr('h25, 0);
      start(0);
      run_to_count("t1_cnt4", 4, 50);
      chk("t1_cyc4", 32'(cyc), 32'd12);
      chk("t1_pc4", pc, 32'd4);
      run_to_count("t1_cnt14", 14, 200);
      chk("t1_cyc14", 32'(cyc), 32'd52);
      run_to_halt("t1", 14, 15);

      // Store then load with three wait states on every access.
      clear_prog();
      prog[0] = enc_i(OP_LI, 0, 1, 5);
      prog[1] = enc_i(OP_SW, 0, 1, 7);
      prog[2] = enc_i(OP_LW, 0, 5, 7);
      prog[3] = enc_i(OP_SW, 0, 5, 'h30);
      push_wr(7, 5);
      push_wr('h30, 5);
      start(3);
      run_to_count("t2_cnt1", 1, 50);
      chk("t2_cyc_li", 32'(cyc), 32'd5);
      run_to_count("t2_cnt2", 2, 50);
      chk("t2_cyc_sw", 32'(cyc), 32'd15);
      run_to_count("t2_cnt3", 3, 50);
      chk("t2_cyc_lw", 32'(cyc), 32'd26);
      run_to_halt("t2", 4, 5);

      // Countdown loop with BNE, then taken and not-taken BEQ.
      clear_prog();
      prog[0]  = enc_i(OP_LI, 0, 1, 3);
      prog[1]  = enc_i(OP_LI, 0, 10, -1);
      prog[2]  = enc_i(OP_LI, 0, 2, 1);
      prog[3]  = enc_i(OP_LI, 0, 3, 0);
      prog[4]  = enc_r(1, 10, 1, FN_ADD);
      prog[5]  = enc_r(3, 2, 3, FN_ADD);
      prog[6]  = enc_i(OP_BNE, 1, 0, -3);
      prog[7]  = enc_i(OP_BEQ, 1, 0, 1);
      prog[8]  = enc_i(OP_LI, 0, 3, 99);
      prog[9]  = enc_i(OP_BEQ, 1, 2, 1);
      prog[10] = enc_i(OP_SW, 0, 3, 'h40);
      push_wr('h40, 3);
      start(0);
      run_to_count("t3_cnt", 16, 200);
      chk("t3_cyc", 32'(cyc), 32'd51);
      run_to_halt("t3", 16, 12);

      // JAL/JR round trip, J, and a discarded write to $0.
      clear_prog();
      prog[0]    = enc_i(OP_LI, 0, 1, 7);
      prog[1]    = enc_j(OP_JAL, 'h10);
      prog[2]    = enc_i(OP_SW, 0, 31, 'h50);
      prog[3]    = enc_i(OP_SW, 0, 5, 'h51);
      prog[4]    = enc_j(OP_J, 'h20);
      prog['h10] = enc_r(1, 1, 0, FN_ADD);
      prog['h11] = enc_i(OP_SW, 0, 0, 'h52);
      prog['h12] = enc_i(OP_LI, 0, 5, 'h1234);
      prog['h13] = enc_r(31, 0, 0, FN_JR);
      push_wr('h52, 0);
      push_wr('h50, 2);
      push_wr('h51, 'h1234);
      start(0);
      run_to_count("t4_cnt2", 2, 50);
      chk("t4_cyc_jal", 32'(cyc), 32'd4);
      chk("t4_pc_jal", pc, 32'h10);
      run_to_halt("t4", 9, 'h21);

      // Reset while an LW is stalled in its memory access.
      clear_prog();
      prog[0] = enc_i(OP_LI, 0, 1, 9);
      prog[1] = enc_i(OP_SW, 0, 1, 3);
      prog[2] = enc_i(OP_LW, 0, 2, 3);
      prog[3] = enc_i(OP_SW, 0, 2, 'h70);
      push_wr(3, 9);
      start(2);
      begin
         int n = 0;
         while (!(mem_req && !mem_we && mem_addr == 10'd3 && instr_count == 32'd2 && !mem_ready)
                && n < 100) begin
            tick();
            n++;
         end
      end
      chk("t5_in_lw_mem", 32'(mem_req && !mem_we && mem_addr == 10'd3), 32'd1);
      clear_prog();
      prog[0] = enc_i(OP_SW, 0, 1, 'h60);
      prog[1] = enc_i(OP_SW, 0, 2, 'h61);
      reset = 1'b1;
      load  = 1'b1;
      #1;
      chk("t5_req_in_rst", 32'(mem_req), 32'd0);
      @(negedge clk);
      chk("t5_rst_pc", pc, 32'd0);
      chk("t5_rst_cnt", instr_count, 32'd0);
      chk("t5_rst_halted", 32'(halted), 32'd0);
      @(negedge clk);
      load       = 1'b0;
      reset      = 1'b0;
      cyc        = 0;
      stall_prev = 1'b0;
      #1;
      chk("t5_refetch_req", 32'(mem_req), 32'd1);
      chk("t5_refetch_addr", 32'(mem_addr), 32'd0);
      push_wr('h60, 0);
      push_wr('h61, 0);
      run_to_halt("t5", 2, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multicycle MIPS-subset processor core, the next generation of the team's multicycle CPU. Memory is external behind a single shared request/ready port with wait-state support, so one core serves both instruction fetch and data access. Adds synchronous reset, BEQ, hardwired-zero `$0`, signed SLT, illegal-opcode halt and a retired-instruction counter. Sits between the system clock/reset and a word-addressed unified memory model or controller.

## Interface
- `XLEN`, 32: datapath/register width; must be ≥ 32.
- `ADDR_W`, 10: memory word-address width; `mem_addr` = low `ADDR_W` bits of PC or ALU result.
- `RESET_PC`, 0: word address loaded into PC on reset.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_req`  out  1  access request; held with address/data stable until accepted.
- `mem_we`  out  1  1 = write (SW), 0 = read.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  XLEN  store data (`rt` value).
- `mem_rdata`  in  XLEN  read data, valid in the cycle `mem_ready`=1.
- `mem_ready`  in  1  access completes on an edge where `mem_req`=1 and `mem_ready`=1.
- `halted`  out  1  core stopped on illegal instruction.
- `pc`  out  XLEN  current PC (word address).
- `instr_count`  out  XLEN  retired instructions, wraps modulo 2^XLEN.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC; on accept IR←`mem_rdata`, PC←PC+1, → DECODE.
- DECODE: A←R[rs], B←R[rt]; then by opcode:
  - J (000010): PC←{PC[XLEN-1:26], IR[25:0]}; retire; → FETCH.
  - JAL (000011): R[31]←PC (already incremented); PC as J; retire; → FETCH.
  - LI (001001): R[rt]←sext(imm); retire; → FETCH.
  - BNE (000101), BEQ (000100): ALUResult←PC+sext(imm); → EXEC.
  - R-type (000000) with func ADD 100000 / SUB 100010 / SLT 101010 / JR 001000, LW (100011), SW (101011), XORI (001110): → EXEC.
  - Any other opcode, or R-type with other func: → HALT.
- EXEC: ADD/SUB A±B mod 2^XLEN; SLT signed compare, result 1/0; XORI A^sext(imm) (sign-extended); → WB. LW/SW ALUResult←A+sext(imm), → MEM. BNE takes if A≠B, BEQ if A=B: PC←ALUResult; retire; → FETCH. JR PC←A; retire; → FETCH.
- MEM: `mem_req`=1, `mem_addr`=ALUResult[ADDR_W-1:0], `mem_we`=SW, `mem_wdata`=B. On accept: SW retire → FETCH; LW MDR←`mem_rdata` → WB.
- WB: LW R[rt]←MDR; XORI R[rt]←ALUResult; R-type R[rd]←ALUResult; retire; → FETCH.
- Writes to R[0] discarded; R[0] always reads 0.
- HALT: absorbing; no requests; `halted`=1 until reset. Illegal instruction does not retire.
- Retire = `instr_count` increments by 1 on that edge.

## Timing
- Reset (any state, including mid-access): next edge PC=`RESET_PC`, state=FETCH, all R[i]=0, IR/A/B/MDR/ALUResult=0, `instr_count`=0, `halted`=0. `mem_req`/`mem_we` are combinational from state, so they deassert immediately while `reset` is high; an abandoned access is not retried.
- `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` are decoded from registered state only, with no combinational path from `mem_ready`.
- Wait states: each `mem_ready`=0 cycle while `mem_req`=1 adds one cycle; outputs held constant.
- Latency with zero wait (`mem_ready` tied 1): J/JAL/LI 2 cycles; BNE/BEQ/JR 3; SW, ADD/SUB/SLT/XORI 4; LW 5. Each FETCH or MEM wait cycle adds 1.
- Branch/jump offsets are word-relative to PC+1. PC and ALUResult arithmetic wrap modulo 2^XLEN.
- Back-to-back: FETCH of the next instruction asserts `mem_req` in the cycle after the retiring edge.

## Test plan
- Reset then zero-wait: LI $1,5; LI $2,-3; ADD $3,$1,$2; SLT $4,$2,$1 -> $3=2, $4=1; `instr_count`=4 after 12 cycles.
- SW $1,7($0) then LW $5,7($0) with `mem_ready` low 3 cycles on every access -> write seen at addr 7 with data 5; $5=5; outputs stable during waits.
- BNE taken/not-taken and BEQ: loop decrementing $1 from 3 to 0 -> exactly 3 taken branches; final PC = loop exit address.
- JAL to 0x10, then JR $31 -> $31 = JAL address+1; PC returns there; ADD writing $0 -> $0 remains 0.
- Opcode 111111 fetched -> `halted`=1 next DECODE edge; no further `mem_req`; `instr_count` frozen.
- Assert `reset` during a stalled LW MEM cycle -> next edge PC=`RESET_PC`, `mem_req` low while `reset` high, registers cleared, fetch restarts at `RESET_PC`.
